latch_load_ctrl: RTL
====================

Name: latch_load_ctrl

Overview:
- Upstream stage for the lab's level-sensitive D latch bank.
- Takes a raw push-button and raw data switches and synchronizes and debounces them.
- On each debounced button press, presents a stable data word on D and a single clean enable window on E.
- D is guaranteed stable for a programmable number of cycles before E rises and after E falls, so the downstream latch never sees D change while transparent.

Parameters:
- WIDTH, 4: data word width driven onto D.
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles before the button state is accepted. This is 10 ms at 100 MHz.
- SETUP_CYCLES, 2: cycles D is held with E low before E rises. Must be ≥1.
- EN_CYCLES, 4: cycles E is held high. Must be ≥1.
- HOLD_CYCLES, 2: cycles D is held with E low after E falls. Must be ≥1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- btn_raw  input  1  raw push-button, asynchronous and bouncy, active-high.
- d_raw  input  WIDTH  raw data switches, asynchronous.
- E  output  1  latch enable to the downstream latch, registered.
- D  output  WIDTH  latch data to the downstream latch, registered.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when a load sequence completes.

Behaviour:
- Clocking and reset:
  - Single clock domain: clk.
  - Reset is asynchronous and active-low (rst_n).
  - Reset forces E=0, D=0, busy=0, done=0, all synchronizer and debounce state to 0, all counters to 0, and FSM=IDLE.
- Input synchronization:
  - btn_raw and each bit of d_raw pass through a 2-flop synchronizer.
  - No logic uses the raw inputs directly.
- Debounce (button only):
  - Counter increments while btn_sync differs from btn_stable and clears when they are equal.
  - When the count reaches DEBOUNCE_CYCLES-1 while still differing, btn_stable takes btn_sync and the counter clears.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
- Request:
  - req is a one-cycle pulse on a 0→1 transition of btn_stable.
  - A release (1→0) produces nothing.
- FSM states are IDLE, SETUP, ENABLE, HOLD, FINISH.
  - IDLE: E=0. On req, D<=d_sync (the only point at which D changes), load the counter with SETUP_CYCLES-1, go to SETUP.
  - SETUP: E=0. When the counter is 0, load EN_CYCLES-1 and go to ENABLE; otherwise decrement.
  - ENABLE: E=1. When the counter is 0, load HOLD_CYCLES-1 and go to HOLD; otherwise decrement.
  - HOLD: E=0. When the counter is 0, go to FINISH; otherwise decrement.
  - FINISH: done=1 for this cycle only, E=0, return to IDLE.
- E is a registered decode of the next state, so E is high for exactly EN_CYCLES cycles.
- Latency from a req cycle:
  - D updates at the next edge.
  - E rises SETUP_CYCLES cycles after D updates.
  - done asserts SETUP_CYCLES+EN_CYCLES+HOLD_CYCLES cycles after D updates.
- busy=1 in SETUP, ENABLE, HOLD and FINISH.
- A req arriving while busy is dropped, not queued. A button release and re-press during busy is also ignored.
- d_raw changes while busy have no effect on D.
- Reset mid-sequence: E drops to 0 immediately (asynchronously) and D clears to 0. No done pulse is produced.
- D holds its last loaded value indefinitely in IDLE.
- Parameter legality: an elaboration-time check fails the build if SETUP_CYCLES, EN_CYCLES or HOLD_CYCLES is 0, or if DEBOUNCE_CYCLES < 1.

Decomposition:
- Shared package ecelab_pkg:
  - FSM state enum (IDLE, SETUP, ENABLE, HOLD, FINISH), 3-bit encoded.
  - Default timing constants: DEBOUNCE_100MHZ_10MS=1000000.
- One natural sub-module, button_debounce. It contains the 2-flop synchronizer, the debounce counter and the rising-edge pulse.
  - Parameter: DEBOUNCE_CYCLES.
  - Ports: clk, rst_n, raw, stable, rise.
- The data synchronizer and FSM stay in latch_load_ctrl.

Test Plan (WIDTH=4, DEBOUNCE_CYCLES=4, SETUP_CYCLES=2, EN_CYCLES=3, HOLD_CYCLES=2; a D_Latch instance is connected to E/D as a checker):
1. Basic load:
   - Stimulus: d_raw=4'hA, btn_raw held high ≥7 cycles.
   - Required: D=4'hA one cycle after req; E high exactly 3 cycles starting 2 cycles later; done pulses once 7 cycles after D changes; latch Q=4'hA.
2. Bounce rejection:
   - Stimulus: btn_raw toggles every 2 cycles for 20 cycles, then settles high.
   - Required: exactly one req and one E window, only after the final stable interval.
3. Data stability:
   - Stimulus: after starting a load with d_raw=4'h3, change d_raw to 4'hC every cycle during busy.
   - Required: D stays 4'h3 throughout SETUP/ENABLE/HOLD; latch Q=4'h3.
4. Request while busy:
   - Stimulus: release and re-press the button (debounced) during ENABLE.
   - Required: no second sequence, busy never drops early, single done.
5. Reset mid-operation:
   - Stimulus: assert rst_n=0 during ENABLE, between clock edges.
   - Required: E=0 and D=0 immediately, busy=0, done never pulses; after release, a new press with d_raw=4'h5 produces a normal sequence.
6. Back-to-back:
   - Stimulus: press with 4'h1; release after done; press with 4'h2.
   - Required: two complete sequences; D 4'h1 then 4'h2; E low for ≥HOLD+SETUP cycles between windows.

Source files
------------

// File: rtl/ecelab_pkg.sv
// Shared types and timing constants for the lab latch-loading blocks.
package ecelab_pkg;

  // Load-sequence FSM states.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    ENABLE = 3'd2,
    HOLD   = 3'd3,
    FINISH = 3'd4
  } ld_state_e;

  // 10 ms of stable input at a 100 MHz clock.
  localparam int unsigned DEBOUNCE_100MHZ_10MS = 1000000;

  // Largest of three cycle counts; sizes the shared phase counter.
  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Synchronizes a raw push-button, debounces it and flags accepted presses.
module button_debounce
  import ecelab_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_100MHZ_10MS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic stable,
  output logic rise
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             stable_q;
  logic             stable_d;
  logic             rise_q;
  logic             rise_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Count consecutive cycles the synchronized level disagrees with the accepted one.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    rise_d = stable_d & ~stable_q;
  end

  // Two-flop synchronizer plus debounce state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;
  assign rise   = rise_q;

endmodule

// File: rtl/latch_load_ctrl.sv
// Drives a level-sensitive latch bank: stable D around a single clean E window per press.
module latch_load_ctrl
  import ecelab_pkg::*;
#(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_100MHZ_10MS,
  parameter int unsigned SETUP_CYCLES    = 2,
  parameter int unsigned EN_CYCLES       = 4,
  parameter int unsigned HOLD_CYCLES     = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_raw,
  input  logic [WIDTH-1:0] d_raw,
  output logic             E,
  output logic [WIDTH-1:0] D,
  output logic             busy,
  output logic             done
);

  localparam int unsigned MAX_CYC = max3(SETUP_CYCLES, EN_CYCLES, HOLD_CYCLES);
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] EN_LD    = CNT_W'(EN_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYCLES - 1);

  // Zero-length phases would let D move while the latch is transparent.
  if (SETUP_CYCLES < 1 || EN_CYCLES < 1 || HOLD_CYCLES < 1 || DEBOUNCE_CYCLES < 1) begin : g_param_err
    $error("latch_load_ctrl: SETUP/EN/HOLD_CYCLES and DEBOUNCE_CYCLES must all be >= 1");
  end

  logic             btn_stable;
  logic             btn_rise;
  logic             req_c;
  logic [WIDTH-1:0] d_sync1_q;
  logic [WIDTH-1:0] d_sync2_q;
  ld_state_e        state_q;
  ld_state_e        state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [WIDTH-1:0] d_q;
  logic [WIDTH-1:0] d_d;
  logic             e_q;
  logic             e_d;
  logic             busy_q;
  logic             busy_d;
  logic             done_q;
  logic             done_d;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw    (btn_raw),
    .stable (btn_stable),
    .rise   (btn_rise)
  );

  // A rise pulse always coincides with the accepted level being high.
  assign req_c = btn_rise & btn_stable;

  // Two-flop synchronizer for the data switches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_sync1_q <= '0;
      d_sync2_q <= '0;
    end else begin
      d_sync1_q <= d_raw;
      d_sync2_q <= d_sync1_q;
    end
  end

  // Sequence FSM; D is captured only on an accepted request in IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    case (state_q)
      IDLE: begin
        if (req_c) begin
          d_d     = d_sync2_q;
          cnt_d   = SETUP_LD;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          cnt_d   = EN_LD;
          state_d = ENABLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ENABLE: begin
        if (cnt_q == '0) begin
          cnt_d   = HOLD_LD;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = FINISH;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    e_d    = (state_d == ENABLE);
    busy_d = (state_d != IDLE);
    done_d = (state_d == FINISH);
  end

  // State, counter and registered output decode of the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      d_q     <= '0;
      e_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      e_q     <= e_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign E    = e_q;
  assign D    = d_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
